// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port 32-bit data memory with byte/half/word access,
// sign/zero extension, alignment checking and a one-cycle registered response.
// Optional feature macro DMEM_CLEAR_EN: when defined, a CLEAR sweep zeroes
// every word after reset before requests are accepted; when undefined the
// block is ready immediately and memory contents are uninitialised.
module dmem_ctrl #(
  parameter int DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          in_ready;
  logic          accept;
  logic          req_err;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic [31:0]   st_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  logic          clr_wr;
  logic [AW-1:0] clr_idx;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;

  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q,   resp_err_d;

  // Address bits above the array size are ignored so the memory aliases.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign idx  = req_addr[AW+1:2];
  assign lane = req_addr[1:0];

`ifdef DMEM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Clear sweep sequencing: one word per cycle, then hand over to READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_wr  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_wr = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  // State and sweep counter; reset always restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready = (state_q == READY);
  assign clr_idx  = cnt_q;
`else
  assign in_ready = 1'b1;
  assign clr_wr   = 1'b0;
  assign clr_idx  = '0;
`endif

  assign req_ready = in_ready & ~rst;
  assign accept    = req_valid & req_ready;

  // Request decode: alignment check, load lane extraction, store lane merge.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase

    rd_word = mem_q[idx];

    ld_byte = rd_word[7:0];
    case (lane)
      2'b00:   ld_byte = rd_word[7:0];
      2'b01:   ld_byte = rd_word[15:8];
      2'b10:   ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (req_size)
      2'b00:   ld_data = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~req_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase

    st_word = rd_word;
    case (req_size)
      2'b00: begin
        case (lane)
          2'b00:   st_word[7:0]   = req_wdata[7:0];
          2'b01:   st_word[15:8]  = req_wdata[7:0];
          2'b10:   st_word[23:16] = req_wdata[7:0];
          default: st_word[31:24] = req_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (req_addr[1]) begin
          st_word[31:16] = req_wdata[15:0];
        end else begin
          st_word[15:0]  = req_wdata[15:0];
        end
      end
      2'b10:   st_word = req_wdata;
      default: st_word = rd_word;
    endcase
  end

  // Single write port shared by the clear sweep and accepted stores.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = st_word;
    if (clr_wr && !rst) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx;
      wr_data = '0;
    end else if (accept && req_we && !req_err) begin
      wr_en   = 1'b1;
      wr_idx  = idx;
      wr_data = st_word;
    end
  end

  // Memory array update.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Response next-state: data only for good loads, zero otherwise.
  always_comb begin
    resp_valid_d = accept;
    resp_err_d   = accept & req_err;
    resp_rdata_d = '0;
    if (accept && !req_we && !req_err) begin
      resp_rdata_d = ld_data;
    end
  end

  // Response registers, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // A response still in flight when reset arrives is discarded.
  assign resp_valid = resp_valid_q & ~rst;
  assign resp_rdata = rst ? 32'h0 : resp_rdata_q;
  assign resp_err   = resp_err_q & ~rst;

endmodule
